// File: rtl/util_fir_dec_pkg.sv
// Shared types and helpers for the multi-channel FIR decimator.
// Holds the controller state encoding, derived-width helpers and output saturation.
package util_fir_dec_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        RND  = 2'd2,
        HOLD = 2'd3
    } state_e;

    function automatic int acc_width(input int data_w, input int coef_w, input int num_taps);
        return data_w + coef_w + $clog2(num_taps);
    endfunction

    function automatic int ratio_width(input int max_dec);
        return $clog2(max_dec) + 1;
    endfunction

    // Clamp a sign-extended value into a w-bit two's complement range.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/util_fir_mac_ch.sv
// One channel of the decimating FIR: delay line, serial MAC over the taps,
// round-half-up back to sample width and saturation.
module util_fir_mac_ch
    import util_fir_dec_pkg::*;
#(
    parameter int                          DATA_W   = 16,
    parameter int                          COEF_W   = 16,
    parameter int                          NUM_TAPS = 8,
    parameter int                          TAP_W    = $clog2(NUM_TAPS),
    parameter logic [NUM_TAPS*COEF_W-1:0]  COEF     = '0
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              shift_en,
    input  logic [DATA_W-1:0] sample,
    input  logic              acc_clr,
    input  logic              mac_en,
    input  logic [TAP_W-1:0]  tap_idx,
    input  logic              rnd_en,
    output logic [DATA_W-1:0] y,
    output logic              sat
);

    localparam int AW = acc_width(DATA_W, COEF_W, NUM_TAPS);
    localparam int PW = DATA_W + COEF_W;
    localparam logic signed [AW-1:0] RND_C = AW'(longint'(1) << (COEF_W - 2));

    logic signed [DATA_W-1:0] dline_reg [NUM_TAPS];
    logic signed [COEF_W-1:0] coef_arr  [NUM_TAPS];
    logic signed [PW-1:0]     prod;
    logic signed [AW-1:0]     acc_reg;
    logic signed [AW-1:0]     rnd_sum;
    logic signed [AW-1:0]     rnd_shr;
    logic signed [63:0]       rnd_wide;
    logic signed [63:0]       sat_val;
    logic [DATA_W-1:0]        y_reg;
    logic                     sat_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TAPS; gi++) begin : g_coef
            assign coef_arr[gi] = COEF[gi*COEF_W +: COEF_W];
        end
    endgenerate

    // Index 0 always holds the newest accepted sample.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                dline_reg[i] <= '0;
            end
        end else if (shift_en) begin
            dline_reg[0] <= $signed(sample);
            for (int i = 1; i < NUM_TAPS; i++) begin
                dline_reg[i] <= dline_reg[i-1];
            end
        end
    end

    assign prod     = PW'(dline_reg[tap_idx]) * PW'(coef_arr[tap_idx]);
    assign rnd_sum  = acc_reg + RND_C;
    assign rnd_shr  = rnd_sum >>> (COEF_W - 1);
    assign rnd_wide = 64'(rnd_shr);
    assign sat_val  = saturate(rnd_wide, DATA_W);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            acc_reg <= '0;
            y_reg   <= '0;
            sat_reg <= 1'b0;
        end else begin
            if (acc_clr) begin
                acc_reg <= '0;
            end else if (mac_en) begin
                acc_reg <= acc_reg + AW'(prod);
            end
            if (rnd_en) begin
                y_reg   <= sat_val[DATA_W-1:0];
                sat_reg <= (sat_val != rnd_wide);
            end
        end
    end

    assign y   = y_reg;
    assign sat = sat_reg;

endmodule

// File: rtl/util_fir_dec_mc.sv
// Multi-channel FIR decimator with runtime ratio, bypass mode and AXI-Stream
// backpressure; one controller sequences the per-channel MAC engines.
module util_fir_dec_mc
    import util_fir_dec_pkg::*;
#(
    parameter int                          NUM_CH   = 2,
    parameter int                          DATA_W   = 16,
    parameter int                          COEF_W   = 16,
    parameter int                          NUM_TAPS = 8,
    parameter int                          MAX_DEC  = 16,
    parameter logic [NUM_TAPS*COEF_W-1:0]  COEF     = {8{16'h1000}}
) (
    input  logic                              aclk,
    input  logic                              areset,
    input  logic                              s_axis_data_tvalid,
    output logic                              s_axis_data_tready,
    input  logic [NUM_CH*DATA_W-1:0]          s_axis_data_tdata,
    input  logic                              decimate,
    input  logic [ratio_width(MAX_DEC)-1:0]   dec_ratio,
    output logic                              m_axis_data_tvalid,
    input  logic                              m_axis_data_tready,
    output logic [NUM_CH*DATA_W-1:0]          m_axis_data_tdata,
    output logic                              sat_pulse
);

    localparam int RW = ratio_width(MAX_DEC);
    localparam int TW = $clog2(NUM_TAPS);

    state_e                   state_reg, state_next;
    logic [TW-1:0]            tap_reg, tap_next;
    logic [RW-1:0]            phase_reg, phase_next;
    logic                     dec_cfg_reg, dec_cfg_next;
    logic [RW-1:0]            ratio_cfg_reg, ratio_cfg_next;
    logic                     run_reg;
    logic                     out_valid_reg;
    logic [NUM_CH*DATA_W-1:0] out_data_reg;
    logic                     sat_reg;

    logic [RW-1:0]            ratio_eff;
    logic [RW-1:0]            ratio_m1;
    logic [RW-1:0]            phase_cur;
    logic                     cfg_change;
    logic                     out_free;
    logic                     s_ready;
    logic                     accept;
    logic                     go_mac;
    logic                     load_byp;
    logic                     load_dec;
    logic [NUM_CH*DATA_W-1:0] y_all;
    logic [NUM_CH-1:0]        sat_all;

    always_comb begin
        ratio_eff = dec_ratio;
        if (dec_ratio == '0) begin
            ratio_eff = RW'(1);
        end else if (dec_ratio > RW'(MAX_DEC)) begin
            ratio_eff = RW'(MAX_DEC);
        end
    end

    // A config change restarts the phase count before the current beat is counted.
    assign ratio_m1   = ratio_eff - RW'(1);
    assign cfg_change = (decimate != dec_cfg_reg) || (ratio_eff != ratio_cfg_reg);
    assign phase_cur  = cfg_change ? '0 : phase_reg;

    assign out_free = !out_valid_reg || m_axis_data_tready;
    assign s_ready  = run_reg && (state_reg == IDLE) && out_free;
    assign accept   = s_axis_data_tvalid && s_ready;
    assign go_mac   = accept && decimate && (phase_cur == ratio_m1);
    assign load_byp = accept && !decimate;
    assign load_dec = (state_reg == HOLD) && out_free;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_reg     <= IDLE;
            tap_reg       <= '0;
            phase_reg     <= '0;
            dec_cfg_reg   <= 1'b0;
            ratio_cfg_reg <= RW'(1);
            run_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            tap_reg       <= tap_next;
            phase_reg     <= phase_next;
            dec_cfg_reg   <= dec_cfg_next;
            ratio_cfg_reg <= ratio_cfg_next;
            run_reg       <= 1'b1;
        end
    end

    always_comb begin
        state_next     = state_reg;
        tap_next       = tap_reg;
        phase_next     = phase_reg;
        dec_cfg_next   = dec_cfg_reg;
        ratio_cfg_next = ratio_cfg_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    dec_cfg_next   = decimate;
                    ratio_cfg_next = ratio_eff;
                    if (!decimate) begin
                        phase_next = '0;
                    end else if (phase_cur == ratio_m1) begin
                        phase_next = '0;
                        tap_next   = '0;
                        state_next = MAC;
                    end else begin
                        phase_next = phase_cur + RW'(1);
                    end
                end
            end
            MAC: begin
                tap_next = tap_reg + TW'(1);
                if (tap_reg == TW'(NUM_TAPS - 1)) begin
                    state_next = RND;
                end
            end
            RND:     state_next = HOLD;
            HOLD: begin
                if (out_free) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            util_fir_mac_ch #(
                .DATA_W   (DATA_W),
                .COEF_W   (COEF_W),
                .NUM_TAPS (NUM_TAPS),
                .TAP_W    (TW),
                .COEF     (COEF)
            ) u_ch (
                .aclk     (aclk),
                .areset   (areset),
                .shift_en (accept),
                .sample   (s_axis_data_tdata[gi*DATA_W +: DATA_W]),
                .acc_clr  (go_mac),
                .mac_en   (state_reg == MAC),
                .tap_idx  (tap_reg),
                .rnd_en   (state_reg == RND),
                .y        (y_all[gi*DATA_W +: DATA_W]),
                .sat      (sat_all[gi])
            );
        end
    endgenerate

    // Output holding register: data stays put until the downstream handshake.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            sat_reg       <= 1'b0;
        end else begin
            if (load_byp) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= s_axis_data_tdata;
                sat_reg       <= 1'b0;
            end else if (load_dec) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= y_all;
                sat_reg       <= |sat_all;
            end else begin
                if (m_axis_data_tready) begin
                    out_valid_reg <= 1'b0;
                end
                sat_reg <= 1'b0;
            end
        end
    end

    assign s_axis_data_tready = s_ready;
    assign m_axis_data_tvalid = out_valid_reg;
    assign m_axis_data_tdata  = out_data_reg;
    assign sat_pulse          = sat_reg;

endmodule

// File: tb/tb_util_fir_dec_mc.sv
// Scoreboard bench for util_fir_dec_mc: a unity-average instance and a gain-2
// instance share the stimulus; a reference model queues expected outputs.
module tb_util_fir_dec_mc;

    localparam int NT      = 8;
    localparam int LAT_DEC = NT + 2;

    logic        aclk = 1'b0;
    logic        areset = 1'b0;
    logic        s_tvalid = 1'b0;
    logic [31:0] s_tdata = '0;
    logic        decimate = 1'b0;
    logic [4:0]  dec_ratio = 5'd1;
    logic        m_tready = 1'b1;

    logic        s_tready_a, m_tvalid_a, sat_a;
    logic [31:0] m_tdata_a;
    logic        s_tready_b, m_tvalid_b, sat_b;
    logic [31:0] m_tdata_b;

    always #5 aclk = ~aclk;

    util_fir_dec_mc dut_a (
        .aclk               (aclk),
        .areset             (areset),
        .s_axis_data_tvalid (s_tvalid),
        .s_axis_data_tready (s_tready_a),
        .s_axis_data_tdata  (s_tdata),
        .decimate           (decimate),
        .dec_ratio          (dec_ratio),
        .m_axis_data_tvalid (m_tvalid_a),
        .m_axis_data_tready (m_tready),
        .m_axis_data_tdata  (m_tdata_a),
        .sat_pulse          (sat_a)
    );

    util_fir_dec_mc #(.COEF({8{16'h2000}})) dut_b (
        .aclk               (aclk),
        .areset             (areset),
        .s_axis_data_tvalid (s_tvalid),
        .s_axis_data_tready (s_tready_b),
        .s_axis_data_tdata  (s_tdata),
        .decimate           (decimate),
        .dec_ratio          (dec_ratio),
        .m_axis_data_tvalid (m_tvalid_b),
        .m_axis_data_tready (m_tready),
        .m_axis_data_tdata  (m_tdata_b),
        .sat_pulse          (sat_b)
    );

    typedef struct {
        logic [31:0] data;
        logic        sat;
        longint      due;
    } exp_t;

    exp_t   sb_q[$];
    longint hist [2][NT];
    int     m_phase;
    logic   m_dec;
    int     m_ratio;
    int     n_tests = 0;
    int     n_fail  = 0;
    int     n_out   = 0;
    longint cyc     = 0;
    bit     chk_b   = 1'b0;
    bit     chk_lat = 1'b0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < NT; k++) hist[c][k] = 0;
        m_phase = 0;
        m_dec   = 1'b0;
        m_ratio = 1;
    endtask

    function automatic int eff_ratio(input logic [4:0] r);
        if (r == 5'd0) return 1;
        if (r > 5'd16) return 16;
        return int'(r);
    endfunction

    task automatic model_accept(input longint c);
        int          er;
        longint      acc;
        longint      y;
        logic [31:0] yd;
        logic        sf;
        exp_t        e;
        er = eff_ratio(dec_ratio);
        if (decimate != m_dec || er != m_ratio) m_phase = 0;
        m_dec   = decimate;
        m_ratio = er;
        for (int ch = 0; ch < 2; ch++) begin
            for (int k = NT - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
            hist[ch][0] = longint'($signed(s_tdata[ch*16 +: 16]));
        end
        if (!decimate) begin
            e.data = s_tdata; e.sat = 1'b0; e.due = c + 1;
            sb_q.push_back(e);
            m_phase = 0;
        end else if (m_phase == er - 1) begin
            m_phase = 0;
            sf = 1'b0;
            yd = '0;
            for (int ch = 0; ch < 2; ch++) begin
                acc = 0;
                for (int k = 0; k < NT; k++) acc += hist[ch][k] * (chk_b ? 64'sd8192 : 64'sd4096);
                y = (acc + 16384) >>> 15;
                if (y > 32767) begin y = 32767; sf = 1'b1; end
                else if (y < -32768) begin y = -32768; sf = 1'b1; end
                yd[ch*16 +: 16] = y[15:0];
            end
            e.data = yd; e.sat = sf; e.due = c + 1 + LAT_DEC;
            sb_q.push_back(e);
        end else begin
            m_phase++;
        end
    endtask

    // Negedge monitor: output-side checks first, then model the acceptance.
    logic        prev_v, prev_r, prev_s;
    logic [31:0] prev_d;
    always @(negedge aclk) begin
        logic        mv, sp, sr;
        logic [31:0] md;
        if (areset) begin
            prev_v = 1'b0; prev_r = 1'b0; prev_s = 1'b0; prev_d = '0;
        end else begin
            mv = chk_b ? m_tvalid_b : m_tvalid_a;
            md = chk_b ? m_tdata_b  : m_tdata_a;
            sp = chk_b ? sat_b      : sat_a;
            sr = chk_b ? s_tready_b : s_tready_a;
            if (prev_v && !prev_r) begin
                check("hold_valid", 64'(mv), 64'd1);
                check("hold_data", 64'(md), 64'(prev_d));
            end
            if (prev_s) check("sat_one_cycle", 64'(sp), 64'd0);
            if (mv && !(prev_v && !prev_r)) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_out", 64'd1, 64'd0);
                end else begin
                    check("sat_pulse", 64'(sp), 64'(sb_q[0].sat));
                    if (chk_lat) check("latency", 64'(cyc), 64'(sb_q[0].due));
                end
            end
            if (mv && m_tready && sb_q.size() > 0) begin
                $display("[TB] out data=0x%08h exp=0x%08h sat=%0d", md, sb_q[0].data, sp);
                check("out_data", 64'(md), 64'(sb_q[0].data));
                void'(sb_q.pop_front());
                n_out++;
            end
            if (s_tvalid && sr) model_accept(cyc);
            prev_v = mv; prev_r = m_tready; prev_d = md; prev_s = sp;
        end
    end

    task automatic send(input logic [31:0] d, output int waited);
        logic ok;
        s_tdata  = d;
        s_tvalid = 1'b1;
        waited   = 0;
        ok       = 1'b0;
        while (!ok && waited < 200) begin
            @(negedge aclk);
            waited++;
            ok = chk_b ? s_tready_b : s_tready_a;
        end
        if (!ok) check("send_timeout", 64'd0, 64'd1);
        @(posedge aclk); #1;
        s_tvalid = 1'b0;
    endtask

    task automatic send_n(input logic [31:0] d, input int n);
        int w;
        for (int i = 0; i < n; i++) send(d, w);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && sb_q.size() != 0; i++) @(negedge aclk);
        check("drain", 64'(sb_q.size()), 64'd0);
        repeat (2) @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge aclk); #1;
        areset = 1'b1;
        model_reset();
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
    endtask

    initial begin
        int w;
        int base;
        model_reset();
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_s_tready", 64'(s_tready_a), 64'd0);
        check("rst_m_tvalid", 64'(m_tvalid_a), 64'd0);
        check("rst_m_tdata", 64'(m_tdata_a), 64'd0);
        check("rst_sat", 64'(sat_a), 64'd0);
        areset = 1'b0;
        repeat (2) @(posedge aclk);
        #1;

        // 1: bypass streaming at full rate
        chk_lat  = 1'b1;
        decimate = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send({16'h2000 + 16'(i), 16'h4000 + 16'(i)}, w);
            check("byp_ready", 64'(w), 64'd1);
        end
        wait_drain();

        // 2: ratio 8 from reset, constant input
        do_reset();
        decimate  = 1'b1;
        dec_ratio = 5'd8;
        base = n_out;
        send_n(32'h2000_4000, 16);
        wait_drain();
        check("dec8_count", 64'(n_out - base), 64'd2);

        // 3: ratio change restarts phase; ratio 0 acts as 1
        dec_ratio = 5'd4;
        base = n_out;
        send(32'h1100_0300, w);
        send(32'hF200_0500, w);
        dec_ratio = 5'd2;
        send(32'h0700_E900, w);
        repeat (15) @(posedge aclk);
        #1;
        check("ratio_chg_early", 64'(n_out - base), 64'd0);
        send(32'h0310_2200, w);
        wait_drain();
        check("ratio_chg_count", 64'(n_out - base), 64'd1);
        dec_ratio = 5'd0;
        base = n_out;
        send(32'h7000_9000, w);
        send(32'h8001_7FFF, w);
        wait_drain();
        check("ratio0_count", 64'(n_out - base), 64'd2);

        // 4: backpressure with ratio 1
        chk_lat   = 1'b0;
        dec_ratio = 5'd1;
        m_tready  = 1'b0;
        send(32'h1234_0567, w);
        s_tdata  = 32'h0ABC_F0F0;
        s_tvalid = 1'b1;
        repeat (30) @(negedge aclk);
        check("bp_s_tready", 64'(s_tready_a), 64'd0);
        check("bp_m_tvalid", 64'(m_tvalid_a), 64'd1);
        @(posedge aclk); #1;
        m_tready = 1'b1;
        send(32'h0ABC_F0F0, w);
        send(32'h5555_AAAA, w);
        wait_drain();

        // 5: saturation on the gain-2 instance
        do_reset();
        chk_b     = 1'b1;
        chk_lat   = 1'b1;
        decimate  = 1'b1;
        dec_ratio = 5'd8;
        send_n(32'h6000_6000, 8);
        send_n(32'hA000_A000, 8);
        wait_drain();
        chk_b = 1'b0;

        // 6: reset in the middle of MAC discards the result
        send_n(32'h0123_0456, 8);
        repeat (3) @(posedge aclk);
        #2 areset = 1'b1;
        model_reset();
        #1;
        check("midrst_m_tvalid", 64'(m_tvalid_a), 64'd0);
        check("midrst_m_tdata", 64'(m_tdata_a), 64'd0);
        check("midrst_sat", 64'(sat_a), 64'd0);
        check("midrst_s_tready", 64'(s_tready_a), 64'd0);
        @(posedge aclk); #1;
        areset = 1'b0;
        repeat (20) @(posedge aclk);
        #1;
        check("midrst_no_out", 64'(m_tvalid_a), 64'd0);
        base = n_out;
        send_n(32'h0200_0100, 7);
        repeat (15) @(posedge aclk);
        #1;
        check("midrst_partial", 64'(n_out - base), 64'd0);
        send(32'h0200_0100, w);
        wait_drain();
        check("midrst_full", 64'(n_out - base), 64'd1);

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
